// File: rtl/adr_fetch_stage_if.sv
// ============================================================================
// Module   : adr_fetch_stage_if
// Purpose  : Bundles the fetch stage's external buses: the instruction-cache
//            read port, the redirect input from execute and the valid/ready
//            instruction stream towards decode.
// Signals  : icache_req_o / icache_addr_o   fetch -> icache request
//            icache_data_i                  icache -> fetch, one cycle later
//            redirect_i / redirect_pc_i     execute -> fetch PC redirect
//            inst_valid_o / inst_o /
//            inst_pc_o                      fetch -> decode head instruction
//            inst_ready_i                   decode -> fetch accept
// Modports : master = fetch stage side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adr_fetch_stage_if #(
  parameter int XLEN     = 32,
  parameter int INST_LEN = 32,
  parameter int IDX_W    = 5
);
  logic                icache_req_o;
  logic [IDX_W-1:0]    icache_addr_o;
  logic [INST_LEN-1:0] icache_data_i;
  logic                redirect_i;
  logic [XLEN-1:0]     redirect_pc_i;
  logic                inst_valid_o;
  logic                inst_ready_i;
  logic [INST_LEN-1:0] inst_o;
  logic [XLEN-1:0]     inst_pc_o;

  modport master (
    output icache_req_o, icache_addr_o,
    input  icache_data_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o, inst_o, inst_pc_o,
    input  inst_ready_i
  );

  modport slave (
    input  icache_req_o, icache_addr_o,
    output icache_data_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o, inst_o, inst_pc_o,
    output inst_ready_i
  );
endinterface

`default_nettype wire

// File: rtl/adr_fetch_stage.sv
// ============================================================================
// Module   : adr_fetch_stage
// Purpose  : Instruction fetch stage in front of a synchronous-read icache.
//            Owns the PC, issues one word-index read per cycle, captures the
//            returned word a cycle later into a small circular FIFO and hands
//            instructions to decode over valid/ready. A redirect from execute
//            flushes the FIFO and the in-flight response.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high
//            fetch_bus  - adr_fetch_stage_if.master (icache, redirect, decode)
//            perf_fetched_o / perf_bubble_o - only with ADR_FETCH_PERF_EN
// Options  : `define ADR_FETCH_PERF_EN adds saturating push / bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adr_fetch_stage #(
  parameter int              XLEN       = 32,
  parameter int              INST_LEN   = 32,
  parameter int              IDX_W      = 5,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  adr_fetch_stage_if.master   fetch_bus
`ifdef ADR_FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched_o,
  output logic [31:0]         perf_bubble_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Two spare bits so count + inflight never overflows before the compare.
  localparam int CNT_W = PTR_W + 2;

  generate
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("adr_fetch_stage: FIFO_DEPTH must be a power of two >= 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("adr_fetch_stage: RESET_PC must be 4-byte aligned");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     req_pc_q, req_pc_d;       // PC of the in-flight request
  logic                inflight_q, inflight_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [INST_LEN-1:0] inst_mem_q [FIFO_DEPTH];
  logic [INST_LEN-1:0] inst_mem_d [FIFO_DEPTH];
  logic [XLEN-1:0]     pc_mem_q   [FIFO_DEPTH];
  logic [XLEN-1:0]     pc_mem_d   [FIFO_DEPTH];

  logic                valid;
  logic                pop;
  logic                push;
  logic                issue;
  logic [CNT_W-1:0]    credit;

  // Low address bits of the redirect target are ignored by design.
  logic                unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^fetch_bus.redirect_pc_i[1:0];

  assign valid = (count_q != '0);
  assign pop   = valid & fetch_bus.inst_ready_i;
  // A response arriving in a redirect cycle belongs to the old path: drop it.
  assign push  = inflight_q & ~fetch_bus.redirect_i;

  // Occupancy the FIFO will have once the outstanding response lands, net of
  // this cycle's pop. Issuing only while this is below depth is what makes
  // overflow impossible.
  assign credit = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
  assign issue  = ~reset & ~fetch_bus.redirect_i & (credit < CNT_W'(FIFO_DEPTH));

  assign fetch_bus.icache_req_o  = issue;
  assign fetch_bus.icache_addr_o = pc_q[IDX_W+1:2];
  assign fetch_bus.inst_valid_o  = valid;
  assign fetch_bus.inst_o        = inst_mem_q[rd_ptr_q];
  assign fetch_bus.inst_pc_o     = pc_mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;

    if (fetch_bus.redirect_i) begin
      // Flush: the pop in this cycle (if any) still completes on the decode
      // side, but the FIFO is emptied regardless.
      pc_d       = {fetch_bus.redirect_pc_i[XLEN-1:2], 2'b00};
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      // When full with a simultaneous pop, wr_ptr equals rd_ptr, so the push
      // overwrites exactly the slot being consumed this cycle.
      if (push) begin
        inst_mem_d[wr_ptr_q] = fetch_bus.icache_data_i;
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      inflight_d = issue;
      if (issue) begin
        pc_d     = pc_q + XLEN'(4);
        req_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  // A push into a full FIFO without a freeing pop means the credit logic broke.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CNT_W'(FIFO_DEPTH)) && !pop));

  // --------------------------------------------------------------------------
  // Optional performance counters (saturating, untouched by redirect)
  // --------------------------------------------------------------------------
`ifdef ADR_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubble_q,  perf_bubble_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubble_d  = perf_bubble_q;
    if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (fetch_bus.inst_ready_i && !valid && (perf_bubble_q != 32'hFFFF_FFFF)) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubble_q  <= perf_bubble_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_bubble_o  = perf_bubble_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adr_fetch_stage.sv
// ============================================================================
// Module   : tb_adr_fetch_stage
// Purpose  : Directed self-checking bench for adr_fetch_stage. The icache is
//            modelled as a synchronous ROM returning 32'h1000 + index.
//            Build with ADR_FETCH_PERF_EN defined to also cover the counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adr_fetch_stage;

  logic clk;
  logic reset;

  adr_fetch_stage_if #(.XLEN(32), .INST_LEN(32), .IDX_W(5)) fbus ();

`ifdef ADR_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  adr_fetch_stage #(
    .XLEN(32), .INST_LEN(32), .IDX_W(5), .RESET_PC(32'h0), .FIFO_DEPTH(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_bus (fbus)
`ifdef ADR_FETCH_PERF_EN
    ,
    .perf_fetched_o (perf_fetched),
    .perf_bubble_o  (perf_bubble)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read icache: data for a request appears the following cycle.
  always @(posedge clk) begin
    if (fbus.icache_req_o) fbus.icache_data_i <= 32'h1000 + {27'd0, fbus.icache_addr_o};
  end

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [31:0] exp_pc;

  logic        s_req, s_valid, s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_pc, s_inst;
`ifdef ADR_FETCH_PERF_EN
  logic [31:0] s_fetched, s_bubble;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, check any accepted
  // instruction against the expected program order, then advance to just
  // after the next rising edge where the caller changes inputs.
  task automatic tick();
    @(negedge clk);
    s_req   = fbus.icache_req_o;
    s_addr  = fbus.icache_addr_o;
    s_valid = fbus.inst_valid_o;
    s_ready = fbus.inst_ready_i;
    s_pc    = fbus.inst_pc_o;
    s_inst  = fbus.inst_o;
`ifdef ADR_FETCH_PERF_EN
    s_fetched = perf_fetched;
    s_bubble  = perf_bubble;
`endif
    if (s_valid && s_ready) begin
      chk("acc_pc", s_pc, exp_pc);
      chk("acc_inst", s_inst, 32'h1000 + {27'd0, exp_pc[6:2]});
      exp_pc  = exp_pc + 32'd4;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    fbus.inst_ready_i   = 1'b1;
    fbus.redirect_i     = 1'b0;
    fbus.redirect_pc_i  = 32'h0;
    fbus.icache_data_i  = 32'h0;
    exp_pc              = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, fbus.inst_valid_o}, 32'd0);
    chk("rst_req",   {31'd0, fbus.icache_req_o}, 32'd0);
    chk("rst_inst",  fbus.inst_o, 32'd0);
    chk("rst_pc",    fbus.inst_pc_o, 32'd0);

    // ---- start-up latency and streaming ----
    reset = 1'b0;
    tick(); chk("c0_req", {31'd0, s_req}, 32'd1); chk("c0_addr", {27'd0, s_addr}, 32'd0);
            chk("c0_valid", {31'd0, s_valid}, 32'd0);
    tick(); chk("c1_valid", {31'd0, s_valid}, 32'd0); chk("c1_addr", {27'd0, s_addr}, 32'd1);
    tick(); chk("c2_valid", {31'd0, s_valid}, 32'd1);
    tick(); tick();
    chk("acc3", acc_cnt, 32'd3);

    // ---- backpressure: FIFO fills to 2, fetch stops, head holds ----
    fbus.inst_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, s_valid}, 32'd1);
      chk("bp_pc", s_pc, 32'h0000_000C);
      chk("bp_inst", s_inst, 32'h0000_1003);
      chk("bp_req", {31'd0, s_req}, 32'd0);
    end
    fbus.inst_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("resume_valid", {31'd0, s_valid}, 32'd1);
    end
    chk("acc9", acc_cnt, 32'd9);

    // ---- redirect while FIFO full ----
    fbus.inst_ready_i = 1'b0;
    repeat (3) tick();
    chk("full_req", {31'd0, s_req}, 32'd0);
    fbus.redirect_i    = 1'b1;
    fbus.redirect_pc_i = 32'h0000_0043;
    tick(); chk("rd_req", {31'd0, s_req}, 32'd0);
    fbus.redirect_i   = 1'b0;
    fbus.inst_ready_i = 1'b1;
    exp_pc            = 32'h0000_0040;
    tick(); chk("rd1_valid", {31'd0, s_valid}, 32'd0); chk("rd1_req", {31'd0, s_req}, 32'd1);
            chk("rd1_addr", {27'd0, s_addr}, 32'd16);
    tick(); chk("rd2_valid", {31'd0, s_valid}, 32'd0);
    tick(); chk("rd3_valid", {31'd0, s_valid}, 32'd1); chk("rd3_pc", s_pc, 32'h0000_0040);
    tick(); tick();

    // ---- redirect coinciding with a pop and an arriving response ----
    fbus.redirect_i    = 1'b1;
    fbus.redirect_pc_i = 32'h0000_0100;
    tick(); chk("rdp_valid", {31'd0, s_valid}, 32'd1); chk("rdp_req", {31'd0, s_req}, 32'd0);
    fbus.redirect_i = 1'b0;
    exp_pc          = 32'h0000_0100;
    tick(); chk("rdp1_valid", {31'd0, s_valid}, 32'd0);
    tick(); chk("rdp2_valid", {31'd0, s_valid}, 32'd0);
    tick(); chk("rdp3_pc", s_pc, 32'h0000_0100); chk("rdp3_inst", s_inst, 32'h0000_1000);

    // ---- back-to-back redirects: the last one wins ----
    fbus.redirect_i    = 1'b1;
    fbus.redirect_pc_i = 32'h0000_0200;
    tick();
    fbus.redirect_pc_i = 32'h0000_0084;
    tick();
    fbus.redirect_i = 1'b0;
    exp_pc          = 32'h0000_0084;
    tick(); tick();
    tick(); chk("b2b_pc", s_pc, 32'h0000_0084); chk("b2b_inst", s_inst, 32'h0000_1001);

    // ---- PC wrap at the top of the address space ----
    fbus.redirect_i    = 1'b1;
    fbus.redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    fbus.redirect_i = 1'b0;
    exp_pc          = 32'hFFFF_FFF8;
    tick(); tick();
    tick(); chk("wrap_pc0", s_pc, 32'hFFFF_FFF8); chk("wrap_inst0", s_inst, 32'h0000_101E);
    tick(); chk("wrap_pc1", s_pc, 32'hFFFF_FFFC); chk("wrap_inst1", s_inst, 32'h0000_101F);
    tick(); chk("wrap_pc2", s_pc, 32'h0000_0000); chk("wrap_inst2", s_inst, 32'h0000_1000);
    tick();

    // ---- asynchronous reset mid-stream ----
    reset = 1'b1;
    #1;
    chk("mr_valid", {31'd0, fbus.inst_valid_o}, 32'd0);
    chk("mr_req",   {31'd0, fbus.icache_req_o}, 32'd0);
    chk("mr_inst",  fbus.inst_o, 32'd0);
    tick();
    reset  = 1'b0;
    exp_pc = 32'h0;
    tick(); chk("mr0_req", {31'd0, s_req}, 32'd1); chk("mr0_addr", {27'd0, s_addr}, 32'd0);
    tick(); chk("mr1_valid", {31'd0, s_valid}, 32'd0);
    tick(); chk("mr2_valid", {31'd0, s_valid}, 32'd1); chk("mr2_pc", s_pc, 32'd0);

`ifdef ADR_FETCH_PERF_EN
    // ---- performance counters ----
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    exp_pc = 32'h0;
    // Cycles 0..10: pushes at the end of cycles 1..10, bubbles in cycles 0,1.
    repeat (11) tick();
    fbus.redirect_i    = 1'b1;
    fbus.redirect_pc_i = 32'h0;
    tick();
    chk("perf_fetched10", s_fetched, 32'd10);
    chk("perf_bubble2",   s_bubble,  32'd2);
    fbus.redirect_i = 1'b0;
    exp_pc          = 32'h0;
    // Redirect drops one response; cycles 12,13 are bubbles, 13 pushes.
    tick(); tick();
    tick();
    chk("perf_fetched11", s_fetched, 32'd11);
    chk("perf_bubble4",   s_bubble,  32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
